// File: rtl/ram_arbiter.sv
// ram_arbiter: two-port arbiter/sequencer for the instruction/data Block RAM.
// Port 0 is the AHB memory interface, port 1 the DMA/UART program loader.
// One access per cycle, locked sequences for read-modify-write, a saturating
// contention counter, and read return following the RAM's one-cycle latency.
// Optional feature: define ARB_ROUND_ROBIN_EN for round-robin arbitration in ARB
// (default build is fixed priority, port 0 wins).
module ram_arbiter #(
    parameter int unsigned ADDR_WIDTH = 14
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic                  m0_lock,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [31:0]           m0_wdata,
    input  logic [3:0]            m0_be,
    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic                  m1_lock,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [31:0]           m1_wdata,
    input  logic [3:0]            m1_be,
    output logic                  m0_gnt,
    output logic                  m1_gnt,
    output logic                  m0_rvalid,
    output logic                  m1_rvalid,
    output logic [31:0]           m0_rdata,
    output logic [31:0]           m1_rdata,
    output logic [ADDR_WIDTH-1:0] ram_addra,
    output logic [ADDR_WIDTH-1:0] ram_addrb,
    output logic [31:0]           ram_dina,
    output logic [3:0]            ram_wea,
    input  logic [31:0]           ram_doutb,
    output logic [15:0]           conflict_cnt
);

    localparam int unsigned CNT_WIDTH = 16;

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    state_t state;
    logic   gnt0;
    logic   gnt1;
    logic   any_gnt;
    logic   win_we;
    logic   contend;
    logic   rd_pend;
    logic   rd_id;

`ifdef ARB_ROUND_ROBIN_EN
    logic   last_win;
`endif

    // Grant decision: lock owner only, otherwise arbitrate between requesters
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        unique case (state)
            ARB: begin
                if (m0_req && m1_req) begin
`ifdef ARB_ROUND_ROBIN_EN
                    gnt0 = last_win;
                    gnt1 = ~last_win;
`else
                    gnt0 = 1'b1;
`endif
                end else begin
                    gnt0 = m0_req;
                    gnt1 = m1_req;
                end
            end
            LOCK0:   gnt0 = m0_req;
            LOCK1:   gnt1 = m1_req;
            default: begin
                gnt0 = 1'b0;
                gnt1 = 1'b0;
            end
        endcase
    end

    assign m0_gnt  = gnt0;
    assign m1_gnt  = gnt1;
    assign any_gnt = gnt0 | gnt1;
    assign win_we  = gnt1 ? m1_we : m0_we;
    assign contend = (m0_req & ~gnt0) | (m1_req & ~gnt1);

    // RAM drive: granted port's access, port 0's lines when idle
    assign ram_addra = gnt1 ? m1_addr : m0_addr;
    assign ram_addrb = gnt1 ? m1_addr : m0_addr;
    assign ram_dina  = gnt1 ? m1_wdata : m0_wdata;
    assign ram_wea   = (gnt0 && m0_we) ? m0_be :
                       (gnt1 && m1_we) ? m1_be : 4'b0000;

    // Read return steered to the original reader
    assign m0_rvalid = rd_pend && (rd_id == 1'b0);
    assign m1_rvalid = rd_pend && (rd_id == 1'b1);
    assign m0_rdata  = ram_doutb;
    assign m1_rdata  = ram_doutb;

    // Lock sequencing FSM
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state <= ARB;
        end else begin
            unique case (state)
                ARB: begin
                    if (gnt0 && m0_lock)      state <= LOCK0;
                    else if (gnt1 && m1_lock) state <= LOCK1;
                end
                LOCK0:   if (!m0_lock) state <= ARB;
                LOCK1:   if (!m1_lock) state <= ARB;
                default: state <= ARB;
            endcase
        end
    end

    // Outstanding-read tracking for the one-cycle RAM latency
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            rd_pend <= 1'b0;
            rd_id   <= 1'b0;
        end else begin
            rd_pend <= any_gnt && !win_we;
            if (any_gnt) rd_id <= gnt1;
        end
    end

    // Saturating contention counter
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            conflict_cnt <= '0;
        end else if (contend && (conflict_cnt != {CNT_WIDTH{1'b1}})) begin
            conflict_cnt <= conflict_cnt + CNT_WIDTH'(1);
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    // Last-winner register for round-robin fairness
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            last_win <= 1'b1;
        end else if (any_gnt) begin
            last_win <= gnt1;
        end
    end
`endif

endmodule
